// File: rtl/hsp_ram_arbiter.sv
// hsp_ram_arbiter
//   Shares one single-port synchronous message RAM between the hi-speed
//   protocol receiver (write requester) and transmitter (read requester).
//   It arbitrates round-robin, sequences each RAM access, and returns
//   rdy pulses and read data to the protocol core.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_l      in   asynchronous active-low reset
//   wr_req     in   write request (level), held until wr_rdy
//   wr_addr    in   write address, stable while wr_req
//   wr_data    in   write data, stable while wr_req
//   wr_rdy     out  1-cycle pulse: write performed
//   rd_req     in   read request (level), held until rd_rdy
//   rd_addr    in   read address, stable while rd_req
//   rd_rdy     out  1-cycle pulse: rd_data valid
//   rd_data    out  read data, registered, held until next read completes
//   ram_en     out  RAM access enable
//   ram_we     out  RAM write enable (only together with ram_en)
//   ram_addr   out  RAM address, registered, holds last value while idle
//   ram_wdata  out  RAM write data, registered, holds last value while idle
//   ram_rdata  in   RAM read data, valid RD_LATENCY cycles after ram_en
//   busy       out  1 whenever the sequencer is not idle
//   state_dbg  out  current sequencer state (debug)
//
// Handshake: a requester raises req with stable addr/data and holds it until
// its rdy pulses for exactly one cycle. The cycle after a completed access is
// a release cycle in which requests are ignored, so the requester can drop req;
// a req still high in the following idle cycle is treated as a new request.

module hsp_ram_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_rdy,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_rdy,
  output logic [DATA_W-1:0] rd_data,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy,
  output logic [2:0]        state_dbg
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WR       = 3'd1;
  localparam logic [2:0] S_RD_ISSUE = 3'd2;
  localparam logic [2:0] S_RD_WAIT  = 3'd3;
  localparam logic [2:0] S_RD_DONE  = 3'd4;
  localparam logic [2:0] S_RELEASE  = 3'd5;

  localparam logic GRANT_WR = 1'b0;
  localparam logic GRANT_RD = 1'b1;

  // RD_WAIT lasts RD_LATENCY cycles; the counter starts at RD_LATENCY-1.
  localparam logic [1:0] LAT_INIT = 2'(RD_LATENCY - 1);

  logic [2:0] state;
  logic [1:0] lat_cnt;
  logic       last_grant;
  logic       pick_wr;
  logic       pick_rd;

  // On a tie the requester that was not served last wins.
  always_comb begin
    pick_wr = wr_req && (!rd_req || (last_grant == GRANT_RD));
    pick_rd = rd_req && !pick_wr;
  end

  // All strobes are registered: they are set on the edge that enters the
  // state in which they must be visible and cleared by default afterwards.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state      <= S_IDLE;
      lat_cnt    <= 2'd0;
      last_grant <= GRANT_RD;
      wr_rdy     <= 1'b0;
      rd_rdy     <= 1'b0;
      rd_data    <= '0;
      ram_en     <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
    end else begin
      ram_en <= 1'b0;
      ram_we <= 1'b0;
      wr_rdy <= 1'b0;
      rd_rdy <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pick_wr) begin
            state      <= S_WR;
            ram_en     <= 1'b1;
            ram_we     <= 1'b1;
            ram_addr   <= wr_addr;
            ram_wdata  <= wr_data;
            wr_rdy     <= 1'b1;
            last_grant <= GRANT_WR;
          end else if (pick_rd) begin
            state      <= S_RD_ISSUE;
            ram_en     <= 1'b1;
            ram_addr   <= rd_addr;
            last_grant <= GRANT_RD;
          end
        end
        S_WR: state <= S_RELEASE;
        S_RD_ISSUE: begin
          lat_cnt <= LAT_INIT;
          state   <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          // The last wait cycle is the one in which ram_rdata is valid.
          if (lat_cnt == 2'd0) begin
            rd_data <= ram_rdata;
            rd_rdy  <= 1'b1;
            state   <= S_RD_DONE;
          end else begin
            lat_cnt <= lat_cnt - 2'd1;
          end
        end
        S_RD_DONE: state <= S_RELEASE;
        S_RELEASE: state <= S_IDLE;
        default:   state <= S_IDLE;
      endcase
    end
  end

  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_hsp_ram_arbiter.sv
module tb_hsp_ram_arbiter;

  // entry = {dut, kind, cycle[15:0], addr[15:0], data[7:0]}
  localparam int W = 43;
  localparam logic [1:0] K_WR = 2'd0;  // write strobe + wr_rdy
  localparam logic [1:0] K_RI = 2'd1;  // read issue (ram_en, !ram_we)
  localparam logic [1:0] K_RD = 2'd2;  // rd_rdy with data
  localparam logic [1:0] K_BAD = 2'd3;

  // ---------------- clock / reset ----------------
  logic clk;
  int   cyc = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // index 0: RD_LATENCY=1, index 1: RD_LATENCY=3
  logic        rst_l     [2];
  logic        wr_req    [2];
  logic [15:0] wr_addr   [2];
  logic [7:0]  wr_data   [2];
  logic        wr_rdy    [2];
  logic        rd_req    [2];
  logic [15:0] rd_addr   [2];
  logic        rd_rdy    [2];
  logic [7:0]  rd_data   [2];
  logic        ram_en    [2];
  logic        ram_we    [2];
  logic [15:0] ram_addr  [2];
  logic [7:0]  ram_wdata [2];
  logic [7:0]  ram_rdata [2];
  logic        busy      [2];
  logic [2:0]  state_dbg [2];

  hsp_ram_arbiter #(.ADDR_W(16), .DATA_W(8), .RD_LATENCY(1)) dut0 (
    .clk(clk), .rst_l(rst_l[0]),
    .wr_req(wr_req[0]), .wr_addr(wr_addr[0]), .wr_data(wr_data[0]), .wr_rdy(wr_rdy[0]),
    .rd_req(rd_req[0]), .rd_addr(rd_addr[0]), .rd_rdy(rd_rdy[0]), .rd_data(rd_data[0]),
    .ram_en(ram_en[0]), .ram_we(ram_we[0]), .ram_addr(ram_addr[0]),
    .ram_wdata(ram_wdata[0]), .ram_rdata(ram_rdata[0]),
    .busy(busy[0]), .state_dbg(state_dbg[0])
  );

  hsp_ram_arbiter #(.ADDR_W(16), .DATA_W(8), .RD_LATENCY(3)) dut1 (
    .clk(clk), .rst_l(rst_l[1]),
    .wr_req(wr_req[1]), .wr_addr(wr_addr[1]), .wr_data(wr_data[1]), .wr_rdy(wr_rdy[1]),
    .rd_req(rd_req[1]), .rd_addr(rd_addr[1]), .rd_rdy(rd_rdy[1]), .rd_data(rd_data[1]),
    .ram_en(ram_en[1]), .ram_we(ram_we[1]), .ram_addr(ram_addr[1]),
    .ram_wdata(ram_wdata[1]), .ram_rdata(ram_rdata[1]),
    .busy(busy[1]), .state_dbg(state_dbg[1])
  );

  // ---------------- RAM models ----------------
  logic [7:0] mem  [2][65536];
  logic [7:0] pipe [2][4];
  logic       loaded = 1'b0;

  always @(posedge clk) begin
    if (!loaded) begin
      mem[0][16'h0100] <= 8'h3C;
      mem[0][16'h0101] <= 8'hC3;
      for (int k = 0; k < 4; k++) mem[0][16'h0300 + k] <= 8'(8'h50 + k);
      mem[1][16'hFFFF] <= 8'h81;
      mem[1][16'h0600] <= 8'h66;
      loaded <= 1'b1;
    end
    for (int d = 0; d < 2; d++) begin
      if (ram_en[d] && ram_we[d]) mem[d][ram_addr[d]] <= ram_wdata[d];
      pipe[d][0] <= (ram_en[d] && !ram_we[d]) ? mem[d][ram_addr[d]] : 8'hEE;
      for (int i = 1; i < 4; i++) pipe[d][i] <= pipe[d][i-1];
    end
  end

  assign ram_rdata[0] = pipe[0][0];
  assign ram_rdata[1] = pipe[1][2];

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void push(input int d, input logic [1:0] k, input int c,
                               input logic [15:0] a, input logic [7:0] dt);
    exp_q.push_back({d[0], k, c[15:0], a, dt});
  endfunction

  // monitor: every cycle with a strobe or rdy is one observed event
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic [1:0]   k;
      logic [15:0]  a;
      logic [7:0]   dt;
      logic [W-1:0] obs;
      chk("we_without_en", {63'b0, ram_we[d] & ~ram_en[d]}, 64'd0);
      if (wr_rdy[d] || rd_rdy[d] || ram_en[d]) begin
        if (ram_en[d] && ram_we[d] && wr_rdy[d] && !rd_rdy[d]) k = K_WR;
        else if (ram_en[d] && !ram_we[d] && !wr_rdy[d] && !rd_rdy[d]) k = K_RI;
        else if (rd_rdy[d] && !ram_en[d] && !wr_rdy[d]) k = K_RD;
        else k = K_BAD;
        a  = (k == K_RD) ? 16'h0000 : ram_addr[d];
        dt = (k == K_WR) ? ram_wdata[d] : (k == K_RD) ? rd_data[d] : 8'h00;
        obs = {d[0], k, cyc[15:0], a, dt};
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_event: got %h required none", obs);
        end else begin
          chk("event", {21'b0, obs}, {21'b0, exp_q.pop_front()});
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_wr(input int d, input logic [15:0] a, input logic [7:0] dt);
    bit got = 1'b0;
    wr_addr[d] = a;
    wr_data[d] = dt;
    wr_req[d]  = 1'b1;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (wr_rdy[d]) got = 1'b1;
    end
    chk("wr_rdy_timeout", {63'b0, got}, 64'd1);
    @(posedge clk); #1;
    wr_req[d] = 1'b0;
  endtask

  task automatic do_rd(input int d, input logic [15:0] a);
    bit got = 1'b0;
    rd_addr[d] = a;
    rd_req[d]  = 1'b1;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (rd_rdy[d]) got = 1'b1;
    end
    chk("rd_rdy_timeout", {63'b0, got}, 64'd1);
    @(posedge clk); #1;
    rd_req[d] = 1'b0;
  endtask

  task automatic check_idle(input int d);
    chk("idle_busy",     {63'b0, busy[d]},      64'd0);
    chk("idle_ram_en",   {63'b0, ram_en[d]},    64'd0);
    chk("idle_ram_we",   {63'b0, ram_we[d]},    64'd0);
    chk("idle_wr_rdy",   {63'b0, wr_rdy[d]},    64'd0);
    chk("idle_rd_rdy",   {63'b0, rd_rdy[d]},    64'd0);
    chk("idle_ram_addr", {48'b0, ram_addr[d]},  64'd0);
    chk("idle_ram_wdat", {56'b0, ram_wdata[d]}, 64'd0);
    chk("idle_rd_data",  {56'b0, rd_data[d]},   64'd0);
    chk("idle_state",    {61'b0, state_dbg[d]}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int c;
    for (int d = 0; d < 2; d++) begin
      rst_l[d] = 1'b0; wr_req[d] = 1'b0; rd_req[d] = 1'b0;
      wr_addr[d] = '0; wr_data[d] = '0; rd_addr[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    check_idle(0);
    check_idle(1);
    @(negedge clk);
    rst_l[0] = 1'b1;
    rst_l[1] = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // 1: single write
    c = cyc;
    push(0, K_WR, c + 1, 16'h0012, 8'hA5);
    wr_addr[0] = 16'h0012; wr_data[0] = 8'hA5; wr_req[0] = 1'b1;
    @(posedge clk); #1;
    chk("t1_busy_c1", {63'b0, busy[0]}, 64'd1);
    @(posedge clk); #1;
    wr_req[0] = 1'b0;
    chk("t1_busy_c2",   {63'b0, busy[0]},      64'd1);
    chk("t1_en_c2",     {63'b0, ram_en[0]},    64'd0);
    chk("t1_rdy_c2",    {63'b0, wr_rdy[0]},    64'd0);
    chk("t1_addr_hold", {48'b0, ram_addr[0]},  64'h0012);
    chk("t1_wdat_hold", {56'b0, ram_wdata[0]}, 64'hA5);
    @(posedge clk); #1;
    chk("t1_busy_c3", {63'b0, busy[0]}, 64'd0);
    repeat (2) @(posedge clk);
    #1;

    // 2: single read, latency 1
    c = cyc;
    push(0, K_RI, c + 1, 16'h0100, 8'h00);
    push(0, K_RD, c + 3, 16'h0000, 8'h3C);
    do_rd(0, 16'h0100);
    repeat (2) @(posedge clk);
    #1;

    // 3: simultaneous write and read, write wins the tie
    c = cyc;
    push(0, K_WR, c + 1, 16'h0020, 8'h11);
    push(0, K_RI, c + 4, 16'h0101, 8'h00);
    push(0, K_RD, c + 6, 16'h0000, 8'hC3);
    fork
      do_wr(0, 16'h0020, 8'h11);
      do_rd(0, 16'h0101);
    join
    repeat (2) @(posedge clk);
    #1;

    // 4: both requesters continuously asserting, grants alternate W,R,...
    c = cyc;
    for (int k = 0; k < 4; k++) begin
      push(0, K_WR, c + 1 + 8 * k, 16'h0200 + 16'(k), 8'h90 + 8'(k));
      push(0, K_RI, c + 4 + 8 * k, 16'h0300 + 16'(k), 8'h00);
      push(0, K_RD, c + 6 + 8 * k, 16'h0000, 8'h50 + 8'(k));
    end
    fork
      begin
        for (int k = 0; k < 4; k++) do_wr(0, 16'h0200 + 16'(k), 8'h90 + 8'(k));
      end
      begin
        for (int k = 0; k < 4; k++) do_rd(0, 16'h0300 + 16'(k));
      end
    join
    repeat (2) @(posedge clk);
    #1;

    // 6: latency-3 read at the top address
    c = cyc;
    push(1, K_RI, c + 1, 16'hFFFF, 8'h00);
    push(1, K_RD, c + 5, 16'h0000, 8'h81);
    do_rd(1, 16'hFFFF);
    repeat (2) @(posedge clk);
    #1;

    // 5: reset in the middle of a latency-3 read
    c = cyc;
    push(1, K_RI, c + 1, 16'h0400, 8'h00);
    rd_addr[1] = 16'h0400;
    rd_req[1]  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("t5_busy_before_rst", {63'b0, busy[1]}, 64'd1);
    rst_l[1]  = 1'b0;
    rd_req[1] = 1'b0;
    #1;
    check_idle(1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_l[1] = 1'b1;
    @(posedge clk); #1;
    c = cyc;
    push(1, K_WR, c + 1, 16'h0500, 8'h77);
    push(1, K_RI, c + 4, 16'h0600, 8'h00);
    push(1, K_RD, c + 8, 16'h0000, 8'h66);
    fork
      do_wr(1, 16'h0500, 8'h77);
      do_rd(1, 16'h0600);
    join

    repeat (10) @(posedge clk);
    #1;
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
